// File: rtl/icache_pkg.sv
// Shared types and constants for the I-cache refill path.
package icache_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned OFFSET_W       = 4;
  localparam int unsigned WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } refill_state_e;

  // Clear the byte-offset bits so the address points at the start of a line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: accepts one line miss, fetches the full line from
// memory in a single beat, writes it into the cache arrays and returns the
// requested word.
// Optional watchdog: define REFILL_TIMEOUT_EN to abort a refill whose memory
// request goes unanswered for TIMEOUT_CYCLES cycles (pulses refill_err).
module icache_refill_ctrl #(
  parameter int unsigned ADDR_W         = icache_pkg::ADDR_W,
  parameter int unsigned LINE_W         = icache_pkg::LINE_W,
  parameter int unsigned WORD_W         = icache_pkg::WORD_W,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_data,
  output logic              refill_err
);

  import icache_pkg::*;

  localparam int unsigned WORDS  = LINE_W / WORD_W;
  localparam int unsigned SEL_W  = $clog2(WORDS);
  localparam int unsigned BYTE_W = $clog2(WORD_W / 8);

  // Elaboration-time sanity check of the configuration against the package.
  if (WORDS != WORDS_PER_LINE || (LINE_W / 8) != (1 << OFFSET_W) ||
      ADDR_W != icache_pkg::ADDR_W || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("icache_refill_ctrl: unsupported parameter combination");
  end

  refill_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  word_sel_q, word_sel_d;

  logic accept;
  logic capture;
  logic timeout;

  logic              miss_ready_d;
  logic              mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              fill_valid_d;
  logic [ADDR_W-1:0] fill_addr_d;
  logic [LINE_W-1:0] fill_data_d;
  logic              resp_valid_d;
  logic [WORD_W-1:0] resp_data_d;
  logic              refill_err_d;

  // Handshake qualifiers: a miss is taken only in IDLE, data only in REQ.
  assign accept  = (state_q == IDLE) && miss_valid;
  assign capture = (state_q == REQ) && mem_ready;

`ifdef REFILL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q;

  // Watchdog: held at zero outside REQ, counts REQ cycles without mem_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q != REQ) begin
      wait_cnt_q <= '0;
    end else if (!mem_ready) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // A late mem_ready in the final cycle still wins over the abort.
  assign timeout = (state_q == REQ) && !mem_ready &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (miss_valid) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = FILL;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the state being entered.
  always_comb begin
    addr_d       = addr_q;
    word_sel_d   = word_sel_q;
    miss_ready_d = 1'b0;
    mem_req_d    = 1'b0;
    mem_addr_d   = '0;
    fill_valid_d = 1'b0;
    fill_addr_d  = '0;
    fill_data_d  = '0;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    refill_err_d = 1'b0;

    if (accept) begin
      addr_d     = ADDR_W'(line_align(miss_addr));
      word_sel_d = miss_addr[BYTE_W +: SEL_W];
    end

    miss_ready_d = (state_d == IDLE);

    if (state_d == REQ) begin
      mem_req_d  = 1'b1;
      mem_addr_d = addr_d;
    end

    if (capture) begin
      fill_valid_d = 1'b1;
      fill_addr_d  = addr_q;
      fill_data_d  = mem_data_in;
      resp_valid_d = 1'b1;
      resp_data_d  = mem_data_in[WORD_W * 32'(word_sel_q) +: WORD_W];
    end

    refill_err_d = timeout;
  end

  // Output and request-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      word_sel_q <= '0;
      miss_ready <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      refill_err <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      word_sel_q <= word_sel_d;
      miss_ready <= miss_ready_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      fill_valid <= fill_valid_d;
      fill_addr  <= fill_addr_d;
      fill_data  <= fill_data_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      refill_err <= refill_err_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus pushes expected memory
// requests and fills into queues, a negedge monitor pops and compares them.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_data_in;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         refill_err;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] line;
    logic [31:0]  word;
  } fill_t;

  fill_t       fill_q[$];
  logic [31:0] req_q[$];
  int          err_exp = 0;
  int          checks  = 0;
  int          errors  = 0;

  localparam logic [127:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_B = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_C = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  icache_refill_ctrl #(
    .ADDR_W(32), .LINE_W(128), .WORD_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_data_in(mem_data_in),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every request and fill the DUT presents.
  logic        req_prev  = 1'b0;
  logic        fill_prev = 1'b0;
  logic [31:0] cur_req   = '0;
  always @(negedge clk) begin
    fill_t e;
    if (!rst) begin
      if (mem_req && !req_prev) begin
        if (req_q.size() == 0) fail("unexpected mem_req");
        else begin
          cur_req = req_q.pop_front();
          check("mem_addr", 128'(mem_addr), 128'(cur_req));
        end
      end else if (mem_req) begin
        check("mem_addr stable", 128'(mem_addr), 128'(cur_req));
      end else begin
        check("mem_addr idle", 128'(mem_addr), 128'(0));
      end
      if (fill_valid) begin
        if (fill_prev) fail("fill_valid wider than one cycle");
        if (fill_q.size() == 0) fail("unexpected fill_valid");
        else begin
          e = fill_q.pop_front();
          check("fill_addr", 128'(fill_addr), 128'(e.addr));
          check("fill_data", fill_data, e.line);
          check("resp_valid", 128'(resp_valid), 128'(1));
          check("resp_data", 128'(resp_data), 128'(e.word));
        end
      end else if (resp_valid) begin
        fail("resp_valid without fill_valid");
      end
      if (refill_err) begin
        if (err_exp == 0) fail("unexpected refill_err");
        else begin
          checks++;
          err_exp--;
        end
      end
    end
    req_prev  = mem_req;
    fill_prev = fill_valid;
  end

  task automatic wait_ready();
    int t = 0;
    while (!miss_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (!miss_ready) fail("miss_ready wait timed out");
  endtask

  // One full refill: accept, hold memory off for 'delay' cycles, return 'line'.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] exp_a,
                         input logic [127:0] line, input logic [31:0] word,
                         input int delay, input logic rdy_at_accept);
    fill_t f;
    wait_ready();
    req_q.push_back(exp_a);
    f.addr = exp_a;
    f.line = line;
    f.word = word;
    fill_q.push_back(f);
    miss_valid  = 1'b1;
    miss_addr   = a;
    mem_ready   = rdy_at_accept;
    mem_data_in = ~line;
    tick(1);
    miss_valid = 1'b0;
    mem_ready  = 1'b0;
    check("mem_req after accept", 128'(mem_req), 128'(1));
    check("miss_ready in REQ", 128'(miss_ready), 128'(0));
    tick(delay);
    mem_ready   = 1'b1;
    mem_data_in = line;
    tick(1);
    mem_ready   = 1'b0;
    mem_data_in = '0;
    check("fill_valid after ready", 128'(fill_valid), 128'(1));
    check("mem_req drop", 128'(mem_req), 128'(0));
    tick(1);
    check("fill_valid one cycle", 128'(fill_valid), 128'(0));
    check("miss_ready back", 128'(miss_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0]  sweep_addr [4];
    logic [31:0]  sweep_word [4];
    fill_t        f;
    int           cnt;

    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_ready = 1'b0; mem_data_in = '0;
    tick(3);
    check("reset miss_ready", 128'(miss_ready), 128'(1));
    check("reset mem_req", 128'(mem_req), 128'(0));
    check("reset mem_addr", 128'(mem_addr), 128'(0));
    check("reset fill_valid", 128'(fill_valid), 128'(0));
    check("reset fill_addr", 128'(fill_addr), 128'(0));
    check("reset fill_data", fill_data, 128'(0));
    check("reset resp_valid", 128'(resp_valid), 128'(0));
    check("reset resp_data", 128'(resp_data), 128'(0));
    check("reset refill_err", 128'(refill_err), 128'(0));
    rst = 1'b0;
    tick(1);

    // Basic refill, memory answers after two cycles.
    do_miss(32'h0000_1238, 32'h0000_1230, LINE_A, 32'hCCCC_CCCC, 2, 1'b0);

    // Word-select sweep across one line.
    sweep_addr = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008, 32'h0000_200C};
    sweep_word = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
    for (int i = 0; i < 4; i++)
      do_miss(sweep_addr[i], 32'h0000_2000, LINE_A, sweep_word[i], i, 1'b0);

    // Minimum latency with mem_ready high at acceptance (must be ignored).
    do_miss(32'h0000_3FFF, 32'h0000_3FF0, LINE_C, 32'h0F0E_0D0C, 0, 1'b1);

    // Back-to-back: miss_valid held high, second address presented during REQ.
    wait_ready();
    req_q.push_back(32'h0000_4440);
    f = '{addr: 32'h0000_4440, line: LINE_B, word: 32'h2222_2222};
    fill_q.push_back(f);
    req_q.push_back(32'h8000_0010);
    f = '{addr: 32'h8000_0010, line: LINE_C, word: 32'h0302_0100};
    fill_q.push_back(f);
    miss_valid = 1'b1; miss_addr = 32'h0000_4444;
    tick(1);
    miss_addr = 32'h8000_0010;
    tick(2);
    check("b2b miss_ready in REQ", 128'(miss_ready), 128'(0));
    mem_ready = 1'b1; mem_data_in = LINE_B;
    tick(1);
    mem_ready = 1'b0; mem_data_in = '0;
    check("b2b miss_ready in FILL", 128'(miss_ready), 128'(0));
    tick(1);
    check("b2b miss_ready idle", 128'(miss_ready), 128'(1));
    tick(1);
    miss_valid = 1'b0;
    check("b2b second mem_req", 128'(mem_req), 128'(1));
    tick(1);
    mem_ready = 1'b1; mem_data_in = LINE_C;
    tick(1);
    mem_ready = 1'b0; mem_data_in = '0;
    check("b2b second fill", 128'(fill_valid), 128'(1));
    tick(1);

    // Spurious mem_ready while IDLE.
    mem_ready = 1'b1; mem_data_in = LINE_B;
    tick(2);
    mem_ready = 1'b0; mem_data_in = '0;
    check("spurious miss_ready", 128'(miss_ready), 128'(1));
    check("spurious mem_req", 128'(mem_req), 128'(0));
    check("spurious fill_valid", 128'(fill_valid), 128'(0));
    do_miss(32'h0000_5004, 32'h0000_5000, LINE_B, 32'h2222_2222, 1, 1'b0);

    // Reset one cycle after mem_req rises; late data must be discarded.
    wait_ready();
    req_q.push_back(32'h0000_6000);
    miss_valid = 1'b1; miss_addr = 32'h0000_6008;
    tick(1);
    miss_valid = 1'b0;
    check("rst test mem_req", 128'(mem_req), 128'(1));
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst mem_req low", 128'(mem_req), 128'(0));
    check("rst miss_ready", 128'(miss_ready), 128'(1));
    check("rst fill_valid", 128'(fill_valid), 128'(0));
    mem_ready = 1'b1; mem_data_in = LINE_A;
    tick(1);
    mem_ready = 1'b0; mem_data_in = '0;
    check("rst no fill", 128'(fill_valid), 128'(0));
    check("rst no resp", 128'(resp_valid), 128'(0));
    tick(1);
    do_miss(32'h0000_7000, 32'h0000_7000, LINE_C, 32'h0302_0100, 3, 1'b0);

`ifdef REFILL_TIMEOUT_EN
    // Memory never answers: request held 8 cycles, then abort.
    wait_ready();
    req_q.push_back(32'h0000_9000);
    err_exp = 1;
    miss_valid = 1'b1; miss_addr = 32'h0000_900C;
    tick(1);
    miss_valid = 1'b0;
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      tick(1);
    end
    check("timeout mem_req cycles", 128'(cnt), 128'(8));
    check("timeout refill_err", 128'(refill_err), 128'(1));
    check("timeout miss_ready", 128'(miss_ready), 128'(1));
    tick(2);
    check("timeout err pulses", 128'(err_exp), 128'(0));
    check("timeout no fill", 128'(fill_valid), 128'(0));
`else
    // Without the watchdog a long stall still completes normally.
    do_miss(32'h0000_9004, 32'h0000_9000, LINE_A, 32'hBBBB_BBBB, 20, 1'b0);
    cnt = 0;
`endif

    tick(2);
    check("fill queue drained", 128'(fill_q.size()), 128'(0));
    check("req queue drained", 128'(req_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
